// File: rtl/tluh_pkg.sv
// Shared TL-UH types, opcode encodings and host-adapter helpers.
// Types only: no latency or backpressure behaviour of its own.
package tluh_pkg;

    localparam int TL_AW      = 32;
    localparam int TL_DW      = 32;
    localparam int TL_DBW     = TL_DW / 8;
    localparam int TL_SZW     = 3;
    localparam int TL_AIW     = 8;
    localparam int TL_DBW_LOG = $clog2(TL_DBW);

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        ArithmeticData = 3'h2,
        LogicalData    = 3'h3,
        Get            = 3'h4,
        Intent         = 3'h5
    } tluh_a_m_op;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1,
        HintAck       = 3'h2
    } tluh_d_m_op;

    localparam logic [2:0] TLUH_ARITH_ADD = 3'h4;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_SEND,
        HS_WAIT,
        HS_ERR
    } tluh_host_state_t;

    typedef struct packed {
        logic                a_valid;
        tluh_a_m_op          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tluh_d_m_op          d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic                d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tluh_d2h_t;

    // Beats needed to move 2^size bytes over a TL_DBW-wide bus.
    function automatic logic [7:0] tluh_num_beats(input logic [TL_SZW-1:0] size);
        logic [7:0] beats;
        beats = 8'd1;
        if (size > TL_SZW'(TL_DBW_LOG)) begin
            beats = 8'd1 << (size - TL_SZW'(TL_DBW_LOG));
        end
        return beats;
    endfunction

endpackage

// File: rtl/tluh_host_adapter.sv
// Single-outstanding host request port to TL-UH A/D channels; A beat 1 cycle after req, response 1 cycle after d_ack.
// A fields hold under a_ready=0; a one-cycle bubble between burst data beats lets the host present the next beat.
module tluh_host_adapter
    import tluh_pkg::*;
#(
    parameter logic [TL_AIW-1:0] SourceId = '0,
    parameter int                MaxBeats = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output tluh_h2d_t         tl_o,
    input  tluh_d2h_t         tl_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [2:0]        opcode_i,
    input  logic [2:0]        param_i,
    input  logic [TL_AW-1:0]  addr_i,
    input  logic [TL_SZW-1:0] size_i,
    input  logic [TL_DBW-1:0] mask_i,
    input  logic [TL_DW-1:0]  wdata_i,
    output logic              wnext_o,
    output logic              rvalid_o,
    output logic [TL_DW-1:0]  rdata_o,
    output logic [1:0]        rop_o,
    output logic              rerr_o,
    output logic              rlast_o
);

    localparam int CW = $clog2(MaxBeats) + 1;

    tluh_host_state_t    r_state;
    logic                r_a_valid;
    logic                r_d_ready;
    tluh_a_m_op          r_opcode;
    logic [2:0]          r_param;
    logic [TL_SZW-1:0]   r_size;
    logic [TL_AIW-1:0]   r_source;
    logic [TL_AW-1:0]    r_addr;
    logic [TL_DBW-1:0]   r_mask;
    logic [TL_DW-1:0]    r_data;
    logic [CW-1:0]       r_a_cnt;
    logic [CW-1:0]       r_d_cnt;
    logic                r_first;
    logic                r_reload;
    logic                r_data_op;
    logic                r_rvalid;
    logic [TL_DW-1:0]    r_rdata;
    logic [1:0]          r_rop;
    logic                r_rerr;
    logic                r_rlast;

    tluh_a_m_op            w_in_op;
    logic [7:0]            w_nbeats;
    logic [7:0]            w_a_beats;
    logic [7:0]            w_d_beats;
    logic                  w_in_data_op;
    logic [TL_DBW_LOG-1:0] w_lane_mask;
    logic [TL_DBW-1:0]     w_get_mask;
    logic                  w_misalign;
    logic                  w_reject;
    logic                  w_a_ack;
    logic                  w_d_hit;
    logic [CW-1:0]         w_a_cnt_nx;
    logic [CW-1:0]         w_d_cnt_nx;
    logic [2:0]            w_dop;
    logic                  w_unused_d;

    assign w_in_op      = tluh_a_m_op'(opcode_i);
    assign w_nbeats     = tluh_num_beats(size_i);
    assign w_in_data_op = (w_in_op == PutFullData) || (w_in_op == PutPartialData) ||
                          (w_in_op == ArithmeticData) || (w_in_op == LogicalData);
    assign w_a_beats    = ((w_in_op == Get) || (w_in_op == Intent)) ? 8'd1 : w_nbeats;
    assign w_d_beats    = ((w_in_op == PutFullData) || (w_in_op == PutPartialData) ||
                           (w_in_op == Intent)) ? 8'd1 : w_nbeats;

    // Sub-word accesses: alignment lanes and the byte mask for data-less requests.
    always_comb begin
        w_lane_mask = '1;
        w_get_mask  = '1;
        if (size_i < TL_SZW'(TL_DBW_LOG)) begin
            w_lane_mask = TL_DBW_LOG'((32'd1 << size_i) - 32'd1);
            w_get_mask  = TL_DBW'(((32'd1 << (32'd1 << size_i)) - 32'd1) << addr_i[TL_DBW_LOG-1:0]);
        end
    end

    assign w_misalign = |(addr_i[TL_DBW_LOG-1:0] & w_lane_mask);
    assign w_reject   = w_misalign || (32'(w_nbeats) > MaxBeats);

    assign w_a_ack    = r_a_valid & tl_i.a_ready;
    assign w_d_hit    = r_d_ready & tl_i.d_valid & (tl_i.d_source == SourceId) & (r_d_cnt != '0);
    assign w_a_cnt_nx = r_a_cnt - CW'(w_a_ack);
    assign w_d_cnt_nx = r_d_cnt - CW'(w_d_hit);
    assign w_dop      = tl_i.d_opcode;
    assign w_unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, w_dop[2]};

    assign gnt_o   = ((r_state == HS_IDLE) && req_i && w_reject) ||
                     ((r_state == HS_SEND) && w_a_ack && r_first);
    assign wnext_o = w_a_ack && r_data_op;

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = r_a_valid;
        tl_o.a_opcode  = r_opcode;
        tl_o.a_param   = r_param;
        tl_o.a_size    = r_size;
        tl_o.a_source  = r_source;
        tl_o.a_address = r_addr;
        tl_o.a_mask    = r_mask;
        tl_o.a_data    = r_data;
        tl_o.d_ready   = r_d_ready;
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign rop_o    = r_rop;
    assign rerr_o   = r_rerr;
    assign rlast_o  = r_rlast;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= HS_IDLE;
            r_a_valid <= 1'b0;
            r_d_ready <= 1'b0;
            r_opcode  <= PutFullData;
            r_param   <= '0;
            r_size    <= '0;
            r_source  <= '0;
            r_addr    <= '0;
            r_mask    <= '0;
            r_data    <= '0;
            r_a_cnt   <= '0;
            r_d_cnt   <= '0;
            r_first   <= 1'b0;
            r_reload  <= 1'b0;
            r_data_op <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rop     <= '0;
            r_rerr    <= 1'b0;
            r_rlast   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_d_hit) begin
                r_rvalid <= 1'b1;
                r_rdata  <= tl_i.d_data;
                r_rop    <= w_dop[1:0];
                r_rerr   <= tl_i.d_error;
                r_rlast  <= (w_d_cnt_nx == '0);
            end
            case (r_state)
                HS_IDLE: begin
                    if (req_i) begin
                        if (w_reject) begin
                            r_state  <= HS_ERR;
                            r_rvalid <= 1'b1;
                            r_rdata  <= '1;
                            r_rop    <= '0;
                            r_rerr   <= 1'b1;
                            r_rlast  <= 1'b1;
                        end else begin
                            r_state   <= HS_SEND;
                            r_a_valid <= 1'b1;
                            r_d_ready <= 1'b1;
                            r_opcode  <= w_in_op;
                            r_param   <= param_i;
                            r_size    <= size_i;
                            r_source  <= SourceId;
                            r_addr    <= addr_i;
                            r_mask    <= w_in_data_op ? mask_i : w_get_mask;
                            r_data    <= w_in_data_op ? wdata_i : '0;
                            r_a_cnt   <= CW'(w_a_beats);
                            r_d_cnt   <= CW'(w_d_beats);
                            r_first   <= 1'b1;
                            r_reload  <= 1'b0;
                            r_data_op <= w_in_data_op;
                        end
                    end
                end
                HS_SEND: begin
                    r_a_cnt <= w_a_cnt_nx;
                    r_d_cnt <= w_d_cnt_nx;
                    // Next burst beat is sampled the cycle after wnext_o.
                    if (r_reload) begin
                        r_data    <= wdata_i;
                        r_mask    <= mask_i;
                        r_a_valid <= 1'b1;
                        r_reload  <= 1'b0;
                    end
                    if (w_a_ack) begin
                        r_first   <= 1'b0;
                        r_a_valid <= 1'b0;
                        r_reload  <= (w_a_cnt_nx != '0);
                    end
                    if (w_a_cnt_nx == '0) begin
                        if (w_d_cnt_nx == '0) begin
                            r_state   <= HS_IDLE;
                            r_d_ready <= 1'b0;
                        end else begin
                            r_state <= HS_WAIT;
                        end
                    end
                end
                HS_WAIT: begin
                    r_d_cnt <= w_d_cnt_nx;
                    if (w_d_cnt_nx == '0) begin
                        r_state   <= HS_IDLE;
                        r_d_ready <= 1'b0;
                    end
                end
                HS_ERR: begin
                    r_state <= HS_IDLE;
                end
                default: begin
                    r_state <= HS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tluh_host_adapter.sv
// Directed bench for tluh_host_adapter: Get/Put/atomic/burst, local rejects, mid-burst reset.
module tb_tluh_host_adapter;
    import tluh_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i;
    tluh_h2d_t         tl_o;
    tluh_d2h_t         tl_i;
    logic              req_i;
    logic              gnt_o;
    logic [2:0]        opcode_i;
    logic [2:0]        param_i;
    logic [TL_AW-1:0]  addr_i;
    logic [TL_SZW-1:0] size_i;
    logic [TL_DBW-1:0] mask_i;
    logic [TL_DW-1:0]  wdata_i;
    logic              wnext_o;
    logic              rvalid_o;
    logic [TL_DW-1:0]  rdata_o;
    logic [1:0]        rop_o;
    logic              rerr_o;
    logic              rlast_o;

    int n_vec = 0;
    int n_err = 0;

    tluh_h2d_t   exp_a;
    logic        gap_v [7];
    logic [7:0]  gap_s [7];
    logic [31:0] gap_d [7];

    always #5 clk = ~clk;

    tluh_host_adapter dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .tl_o     (tl_o),
        .tl_i     (tl_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .opcode_i (opcode_i),
        .param_i  (param_i),
        .addr_i   (addr_i),
        .size_i   (size_i),
        .mask_i   (mask_i),
        .wdata_i  (wdata_i),
        .wnext_o  (wnext_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .rop_o    (rop_o),
        .rerr_o   (rerr_o),
        .rlast_o  (rlast_o)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_req(input logic [2:0] op, input logic [2:0] prm, input logic [31:0] a,
                            input logic [2:0] sz, input logic [31:0] wd);
        req_i    = 1'b1;
        opcode_i = op;
        param_i  = prm;
        addr_i   = a;
        size_i   = sz;
        wdata_i  = wd;
        mask_i   = 4'hF;
    endtask

    initial begin
        int nb;
        logic good;
        rst_i    = 1'b1;
        tl_i     = '0;
        req_i    = 1'b0;
        opcode_i = '0;
        param_i  = '0;
        addr_i   = '0;
        size_i   = '0;
        mask_i   = '0;
        wdata_i  = '0;
        gap_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        gap_s = '{8'h0, 8'h0, 8'h5, 8'h0, 8'h0, 8'h0, 8'h0};
        gap_d = '{32'h100, 32'h0, 32'hBAD, 32'h101, 32'h0, 32'h102, 32'h103};
        cyc();
        cyc();
        #1;
        chk("reset_tl_o", tl_o, '0);
        chk("reset_resp", {gnt_o, wnext_o, rvalid_o, rdata_o, rop_o, rerr_o, rlast_o}, '0);
        rst_i = 1'b0;

        // Single-beat Get
        cyc();
        host_req(Get, 3'h0, 32'h40, 3'd2, 32'h0);
        #1;
        chk("get_gnt_idle", gnt_o, 1'b0);
        cyc();
        req_i = 1'b0;
        chk("get_a_valid", tl_o.a_valid, 1'b1);
        chk("get_a_opcode", tl_o.a_opcode, Get);
        chk("get_a_addr", tl_o.a_address, 32'h40);
        chk("get_a_mask", tl_o.a_mask, 4'hF);
        chk("get_d_ready", tl_o.d_ready, 1'b1);
        tl_i.a_ready = 1'b1;
        #1;
        chk("get_gnt", gnt_o, 1'b1);
        chk("get_wnext", wnext_o, 1'b0);
        cyc();
        tl_i.a_ready = 1'b0;
        chk("get_a_valid_drop", tl_o.a_valid, 1'b0);
        tl_i.d_valid  = 1'b1;
        tl_i.d_opcode = AccessAckData;
        tl_i.d_source = 8'h0;
        tl_i.d_data   = 32'hDEADBEEF;
        cyc();
        tl_i.d_valid = 1'b0;
        chk("get_rvalid", rvalid_o, 1'b1);
        chk("get_rdata", rdata_o, 32'hDEADBEEF);
        chk("get_rop", rop_o, 2'd1);
        chk("get_rlast_rerr", {rlast_o, rerr_o}, 2'b10);
        chk("get_d_ready_idle", tl_o.d_ready, 1'b0);
        cyc();
        chk("get_rvalid_pulse", rvalid_o, 1'b0);

        // Get burst of 4 beats with gaps and one foreign-source beat
        host_req(Get, 3'h0, 32'h80, 3'd4, 32'h0);
        cyc();
        req_i = 1'b0;
        chk("burst_a_size", tl_o.a_size, 3'd4);
        tl_i.a_ready = 1'b1;
        #1;
        chk("burst_gnt", gnt_o, 1'b1);
        cyc();
        tl_i.a_ready = 1'b0;
        nb = 0;
        for (int i = 0; i < 7; i++) begin
            tl_i.d_valid  = gap_v[i];
            tl_i.d_source = gap_s[i];
            tl_i.d_data   = gap_d[i];
            tl_i.d_opcode = AccessAckData;
            #1;
            chk("burst_d_ready", tl_o.d_ready, 1'b1);
            chk("burst_one_a_beat", tl_o.a_valid, 1'b0);
            cyc();
            good = gap_v[i] && (gap_s[i] == 8'h0);
            chk("burst_rvalid", rvalid_o, good);
            if (good) begin
                chk("burst_rdata", rdata_o, gap_d[i]);
                chk("burst_rlast", rlast_o, nb == 3);
                nb++;
            end
        end
        tl_i.d_valid = 1'b0;
        chk("burst_d_ready_end", tl_o.d_ready, 1'b0);

        // PutFullData, 2 beats, 3-cycle a_ready stall
        cyc();
        host_req(PutFullData, 3'h0, 32'h100, 3'd3, 32'h11111111);
        cyc();
        req_i = 1'b0;
        exp_a = '0;
        exp_a.a_valid   = 1'b1;
        exp_a.a_opcode  = PutFullData;
        exp_a.a_size    = 3'd3;
        exp_a.a_address = 32'h100;
        exp_a.a_mask    = 4'hF;
        exp_a.a_data    = 32'h11111111;
        exp_a.d_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("put_stall_fields", tl_o, exp_a);
            chk("put_stall_pulses", {gnt_o, wnext_o}, 2'b00);
            cyc();
        end
        tl_i.a_ready = 1'b1;
        #1;
        chk("put_beat1_pulses", {gnt_o, wnext_o}, 2'b11);
        cyc();
        wdata_i = 32'h22222222;
        #1;
        chk("put_bubble", {tl_o.a_valid, gnt_o, wnext_o}, 3'b000);
        cyc();
        exp_a.a_data = 32'h22222222;
        chk("put_beat2_fields", tl_o, exp_a);
        chk("put_beat2_pulses", {gnt_o, wnext_o}, 2'b01);
        cyc();
        tl_i.a_ready = 1'b0;
        chk("put_a_done", tl_o.a_valid, 1'b0);
        tl_i.d_valid  = 1'b1;
        tl_i.d_opcode = AccessAck;
        tl_i.d_data   = 32'h0;
        cyc();
        tl_i.d_valid = 1'b0;
        chk("put_resp", {rvalid_o, rlast_o, rerr_o, rop_o}, 5'b11000);

        // ArithmeticData ADD with a_ack and d_ack in the same cycle
        cyc();
        host_req(ArithmeticData, TLUH_ARITH_ADD, 32'h200, 3'd2, 32'h3);
        cyc();
        req_i = 1'b0;
        chk("atom_a_fields", {tl_o.a_opcode, tl_o.a_param, tl_o.a_data}, {ArithmeticData, 3'h4, 32'h3});
        tl_i.a_ready  = 1'b1;
        tl_i.d_valid  = 1'b1;
        tl_i.d_opcode = AccessAckData;
        tl_i.d_data   = 32'h5;
        tl_i.d_error  = 1'b1;
        #1;
        chk("atom_pulses", {gnt_o, wnext_o}, 2'b11);
        cyc();
        tl_i = '0;
        chk("atom_rdata", rdata_o, 32'h5);
        chk("atom_resp", {rvalid_o, rerr_o, rlast_o, rop_o}, 5'b11101);
        chk("atom_idle", {tl_o.a_valid, tl_o.d_ready}, 2'b00);

        // Local rejects: misaligned, then too many beats
        cyc();
        host_req(Get, 3'h0, 32'h41, 3'd2, 32'h0);
        #1;
        chk("misalign_gnt", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0;
        chk("misalign_resp", {rvalid_o, rerr_o, rlast_o, rdata_o}, {3'b111, 32'hFFFFFFFF});
        chk("misalign_no_a", tl_o.a_valid, 1'b0);
        cyc();
        chk("misalign_pulse", rvalid_o, 1'b0);
        host_req(Get, 3'h0, 32'h40, 3'd6, 32'h0);
        #1;
        chk("oversize_gnt", gnt_o, 1'b1);
        cyc();
        req_i = 1'b0;
        chk("oversize_resp", {rvalid_o, rerr_o, rlast_o, rdata_o}, {3'b111, 32'hFFFFFFFF});
        chk("oversize_no_a", tl_o.a_valid, 1'b0);
        cyc();

        // Reset after 2 of 4 burst D beats, then a clean single Get
        host_req(Get, 3'h0, 32'h300, 3'd4, 32'h0);
        cyc();
        req_i = 1'b0;
        tl_i.a_ready = 1'b1;
        cyc();
        tl_i.a_ready  = 1'b0;
        tl_i.d_valid  = 1'b1;
        tl_i.d_opcode = AccessAckData;
        tl_i.d_data   = 32'hA0;
        cyc();
        tl_i.d_data = 32'hA1;
        cyc();
        chk("rst_pre_beat2", {rvalid_o, rlast_o, rdata_o}, {2'b10, 32'hA1});
        rst_i = 1'b1;
        tl_i.d_valid = 1'b0;
        cyc();
        rst_i = 1'b0;
        chk("rst_abandon", {tl_o.a_valid, tl_o.d_ready, rvalid_o}, 3'b000);
        tl_i.d_valid = 1'b1;
        tl_i.d_data  = 32'hA2;
        cyc();
        chk("idle_d_not_taken", {tl_o.d_ready, rvalid_o}, 2'b00);
        tl_i.d_valid = 1'b0;
        host_req(Get, 3'h0, 32'h44, 3'd2, 32'h0);
        cyc();
        req_i = 1'b0;
        chk("post_rst_a", {tl_o.a_valid, tl_o.a_address}, {1'b1, 32'h44});
        tl_i.a_ready = 1'b1;
        cyc();
        tl_i.a_ready  = 1'b0;
        tl_i.d_valid  = 1'b1;
        tl_i.d_data   = 32'h12345678;
        cyc();
        tl_i.d_valid = 1'b0;
        chk("post_rst_resp", {rvalid_o, rlast_o, rerr_o, rdata_o}, {3'b110, 32'h12345678});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
